// File: rtl/soc_ram_pkg.sv
// Shared definitions for the SOC on-chip RAM family.
// Contents:
//   ram_state_e        - controller state (CLEAR while zero-filling, RUN for traffic)
//   READ_LATENCY_MIN/MAX - legal range of the read pipeline depth
//   byte_lanes()       - number of 8-bit lanes in a data word
//   byte_parity()      - even-parity bit for one byte
package soc_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Parity bit that makes the byte plus parity contain an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/soc_ram_array.sv
// Inferred single-port RAM with per-byte write enables and a registered read.
// One address serves both the write and the read port.
// Optional macro SOC_RAM_PARITY_EN adds one stored even-parity bit per byte.
// Ports:
//   clk, reset_n - clock, async active-low reset (read register only)
//   addr         - word address shared by write and read
//   we           - per-byte write enables
//   wdata        - write data
//   re           - load the read register from addr
//   rdata        - registered read data (holds while re=0)
//   rpar         - registered stored parity (only with SOC_RAM_PARITY_EN)
module soc_ram_array
  import soc_ram_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = $clog2(DEPTH),
  localparam int LANES  = byte_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
`ifdef SOC_RAM_PARITY_EN
  output logic [LANES-1:0]  rpar,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

`ifdef SOC_RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];

  // Parity is generated from the incoming byte, so an all-zero clear word stores parity 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) par_mem[addr][i] <= byte_parity(wdata[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpar <= '0;
    end else if (re) begin
      rpar <= par_mem[addr];
    end
  end
`endif

endmodule

// File: rtl/soc_onchip_ram_pipe.sv
// Parametrised on-chip RAM with an Avalon-MM slave and a 1- or 2-stage read pipeline.
// After reset an optional sequence zero-fills the array before traffic is accepted.
// Optional macro SOC_RAM_PARITY_EN enables per-byte parity storage and checking.
// Ports:
//   clk, reset_n              - clock, async active-low reset
//   chipselect, address, byteenable, read, write, writedata - Avalon-MM request
//   clken, reset_req          - global enable; both must allow for anything to move
//   freeze                    - write protect (writes are accepted but dropped)
//   waitrequest               - request not accepted this cycle
//   readdata, readdatavalid   - read response
//   init_done                 - clear sequence finished
//   parity_err                - parity mismatch strobe with readdatavalid
module soc_onchip_ram_pipe
  import soc_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  clken,
  input  logic                  reset_req,
  input  logic                  freeze,
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  init_done,
  output logic                  parity_err
);

  localparam int LANES = byte_lanes(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam bit TWO_STAGE = (READ_LATENCY >= READ_LATENCY_MAX);

  logic              en;
  ram_state_e        state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic              accept, acc_rd, acc_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [LANES-1:0]  ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rd_q;
  logic              v1, v_out;
  logic [DATA_W-1:0] d_out;

  assign en = clken & ~reset_req;

  // Next state, clear counter and waitrequest.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    waitrequest  = (state != ST_RUN) | ~en;
    if (en && state == ST_CLEAR) begin
      if (clr_cnt == LAST_ADDR) begin
        state_next   = ST_RUN;
        clr_cnt_next = '0;
      end else begin
        clr_cnt_next = clr_cnt + ADDR_W'(1);
      end
    end
  end

  // init_done follows the registered state, so it rises together with RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (en) begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      init_done <= (state_next == ST_RUN);
    end
  end

  assign accept = chipselect & (read | write) & ~waitrequest;
  assign acc_wr = accept & write;
  assign acc_rd = accept & read & ~write;

  // The clear sequence owns the port while in CLEAR and ignores freeze.
  always_comb begin
    ram_addr  = address;
    ram_we    = '0;
    ram_wdata = writedata;
    if (state == ST_CLEAR) begin
      ram_addr  = clr_cnt;
      ram_wdata = '0;
      ram_we    = {LANES{en}};
    end else if (acc_wr && !freeze) begin
      ram_we = byteenable;
    end
  end

`ifdef SOC_RAM_PARITY_EN
  logic [LANES-1:0] rd_par, par_out, par_calc;
`endif

  soc_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (ram_addr),
    .we      (ram_we),
    .wdata   (ram_wdata),
    .re      (acc_rd),
`ifdef SOC_RAM_PARITY_EN
    .rpar    (rd_par),
`endif
    .rdata   (rd_q)
  );

  // Valid for the array read register; frozen with the rest of the pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1 <= acc_rd;
    end
  end

  generate
    if (TWO_STAGE) begin : g_lat2
      logic              v2;
      logic [DATA_W-1:0] d2;
`ifdef SOC_RAM_PARITY_EN
      logic [LANES-1:0]  p2;
`endif
      // Extra output stage; data only moves when a valid word arrives so it holds otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2 <= 1'b0;
          d2 <= '0;
`ifdef SOC_RAM_PARITY_EN
          p2 <= '0;
`endif
        end else if (en) begin
          v2 <= v1;
          if (v1) begin
            d2 <= rd_q;
`ifdef SOC_RAM_PARITY_EN
            p2 <= rd_par;
`endif
          end
        end
      end
      assign v_out = v2;
      assign d_out = d2;
`ifdef SOC_RAM_PARITY_EN
      assign par_out = p2;
`endif
    end else begin : g_lat1
      assign v_out = v1;
      assign d_out = rd_q;
`ifdef SOC_RAM_PARITY_EN
      assign par_out = rd_par;
`endif
    end
  endgenerate

  // Gating with en keeps a stalled valid from being seen more than once.
  assign readdatavalid = v_out & en;
  assign readdata      = d_out;

`ifdef SOC_RAM_PARITY_EN
  always_comb begin
    par_calc = '0;
    for (int i = 0; i < LANES; i++) begin
      par_calc[i] = byte_parity(d_out[i*8 +: 8]);
    end
  end
  assign parity_err = readdatavalid & (par_calc != par_out);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/soc_onchip_ram_pipe.md
Name: soc_onchip_ram_pipe

Overview:
Parametrised single-port on-chip RAM with an Avalon-MM slave and pipelined reads. Successor to the fixed 128x16 SOC scratch memories.
- Adds configurable width, depth and read latency.
- Adds readdatavalid/waitrequest handshaking.
- Adds an optional post-reset zero-clear sequence.
- Sits on the SOC interconnect as a general data/scratch memory; the array is inferred, not a vendor RAM primitive.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
DEPTH, 1024, number of words
ADDR_W, $clog2(DEPTH), word address width
READ_LATENCY, 1, accepted read to readdatavalid in enabled cycles; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting traffic

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous assert, active-low
chipselect  in  1  slave select
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  per-byte write enable
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
clken  in  1  global clock enable
reset_req  in  1  reset-pending request; blocks all access
freeze  in  1  write protect (partial-reconfig freeze)
waitrequest  out  1  slave busy; request not accepted
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata valid strobe, one cycle
init_done  out  1  clear sequence finished
parity_err  out  1  read parity mismatch strobe (0 unless macro enabled)

Behaviour:
- Enable: en = clken & ~reset_req. No state, memory or pipeline changes when en=0.
- Reset values: waitrequest=1, readdata=0, readdatavalid=0, init_done=0, parity_err=0. Pipeline valid bits cleared; array contents are not reset.
- FSM states: CLEAR, RUN.
  - After reset: CLEAR if CLEAR_ON_RESET=1, otherwise RUN with init_done=1 on the first clock.
  - CLEAR: a counter writes all-zero words to addresses 0..DEPTH-1, one per enabled cycle, all bytes enabled, ignoring freeze.
  - When the counter reaches DEPTH-1 (wrap): go to RUN and set init_done=1 on the following cycle.
  - reset_n asserted mid-CLEAR restarts the sequence at address 0.
- waitrequest = (state!=RUN) | ~en.
- Accept: chipselect & (read|write) & ~waitrequest.
- Write:
  - Bytes with byteenable=1 are updated in the cycle after accept.
  - Bytes with byteenable=0 are unchanged.
  - With freeze=1 the write is still accepted (waitrequest low) but the array is not modified.
- Read:
  - The array is read synchronously at accept.
  - READ_LATENCY=1: readdata/readdatavalid appear on the next enabled edge.
  - READ_LATENCY=2: one extra output register stage.
  - readdatavalid pulses for exactly one cycle per accepted read.
  - readdata holds its last value when readdatavalid=0.
- Stall: while en=0 the read pipeline freezes and readdatavalid is forced 0. In-flight data emerges on resumption and is never dropped or duplicated.
- Read and write asserted together: the write is performed and the read is ignored (no readdatavalid).
- Read-after-write to the same address in consecutive accepts returns the new data. Same-cycle read-during-write is not possible on a single port.
- Throughput: one accept per enabled cycle. Back-to-back reads produce back-to-back readdatavalid.

Optional Feature:
SOC_RAM_PARITY_EN
- Defined:
  - The array stores one even-parity bit per byte, written alongside each enabled byte; CLEAR writes parity 0.
  - On read, parity is recomputed at the output stage.
  - Any byte mismatch pulses parity_err together with readdatavalid; readdata is still returned.
- Undefined: no parity storage, and parity_err is tied to 0.

Decomposition:
- Shared package soc_ram_pkg: state enum (CLEAR, RUN), READ_LATENCY legality constant, function for byte-lane count, function for byte parity.
- One sub-module, soc_ram_array: inferred byte-enabled synchronous RAM, one write port and one read port on the same address, optional parity columns.
- Top level holds the FSM, clear counter, handshake and latency pipeline.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: release reset_n, hold en=1 -> waitrequest=1 for exactly 16 cycles, init_done rises next cycle, a read of every address returns 0.
- Write 0xDEADBEEF to addr 5 with byteenable=4'b0101, then read addr 5 -> readdata=0x00AD00EF, readdatavalid 1 cycle after accept at READ_LATENCY=1, 2 cycles after at READ_LATENCY=2.
- Four back-to-back reads of addrs 0-3 with clken dropped for 3 cycles mid-burst -> exactly four readdatavalid pulses in address order, none while clken=0.
- freeze=1, write 0x12345678 to addr 2 -> accepted (waitrequest=0), subsequent read returns the prior value.
- Assert reset_n at clear counter=7, release -> clear restarts at 0, and init_done rises only after a full DEPTH-cycle sequence.
- SOC_RAM_PARITY_EN: force a flip of one stored data bit of addr 3, then read -> parity_err=1 coincident with readdatavalid; a read of a clean address gives parity_err=0.
